seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It sits downstream of the switch/button controller. That stage supplies a 16-bit hex value, 4 decimal points and a blanking latch-enable. This block decodes one nibble at a time into the {p,g,f,e,d,c,b,a} segment format and cycles the digit anodes. New values are applied only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg7_scan_driver.sv | 123 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : 4-digit common-anode 7-seg scanner with frame-aligned value commit
// Revision : 1.0
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  points,
    input  logic        le,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame
);

    localparam int                 c_PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [1:0]         r_idx;
    logic [15:0]        r_pend_data;
    logic [3:0]         r_pend_pts;
    logic               r_pend_valid;
    logic [15:0]        r_act_data;
    logic [3:0]         r_act_pts;
    logic [3:0]         r_an;
    logic [7:0]         r_seg;
    logic               r_frame;

    logic               w_tick;
    logic               w_commit;
    logic [3:0]         w_nibble;
    logic [6:0]         w_glyph;

    assign w_tick   = (r_pre == c_PRE_LAST);
    assign w_commit = w_tick && (r_idx == 2'd3) && r_pend_valid;
    assign w_nibble = r_act_data[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // A load coinciding with a commit keeps pending_valid set so it lands next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= 16'h0000;
            r_pend_pts   <= 4'h0;
            r_pend_valid <= 1'b0;
            r_act_data   <= 16'h0000;
            r_act_pts    <= 4'h0;
            r_frame      <= 1'b0;
        end else begin
            r_frame <= w_commit;
            if (w_commit) begin
                r_act_data <= r_pend_data;
                r_act_pts  <= r_pend_pts;
            end
            if (load) begin
                r_pend_data  <= data;
                r_pend_pts   <= points;
                r_pend_valid <= 1'b1;
            end else if (w_commit) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_glyph = 7'h7F;
        case (w_nibble)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            4'hF: w_glyph = 7'h0E;
            default: w_glyph = 7'h7F;
        endcase
    end

    // Display registers sample the pre-edge digit, so they trail idx by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else if (le) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= {~r_act_pts[r_idx], w_glyph};
        end
    end

    assign AN      = r_an;
    assign SEGMENT = r_seg;
    assign frame   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : scoreboard bench for seg7_scan_driver with SCAN_DIV = 4
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] data   = 16'h0000;
    logic [3:0]  points = 4'h0;
    logic        le     = 1'b0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data    (data),
        .points  (points),
        .le      (le),
        .AN      (an),
        .SEGMENT (seg),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          is_cnt;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic        frm;
        int          fcnt;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc    = 0;
    int unsigned base   = 0;
    int          checks = 0;
    int          errors = 0;
    int          fcount = 0;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    task automatic push_disp(input int unsigned n, input logic [3:0] a, input logic [7:0] s,
                             input logic f, input string nm);
        exp_t e;
        e.cyc = base + n; e.is_cnt = 1'b0; e.an = a; e.seg = s; e.frm = f; e.fcnt = 0; e.name = nm;
        q.push_back(e);
    endtask

    task automatic push_cnt(input int unsigned n, input int cnt, input string nm);
        exp_t e;
        e.cyc = base + n; e.is_cnt = 1'b1; e.an = 4'h0; e.seg = 8'h00; e.frm = 1'b0; e.fcnt = cnt; e.name = nm;
        q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load is held high across edge number n (relative to release).
    task automatic load_at(input int unsigned n, input logic [15:0] d, input logic [3:0] p);
        wait_until(base + n - 1);
        data   = d;
        points = p;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load   = 1'b0;
    endtask

    // Monitor: samples on the falling edge and retires every expectation due this cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame === 1'b1) fcount++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: sampled late at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end else if (e.is_cnt) begin
                    if (fcount != e.fcnt) begin
                        errors++;
                        $display("FAIL %s: frame pulses %0d, required %0d", e.name, fcount, e.fcnt);
                    end
                end else if ({an, seg, frame} !== {e.an, e.seg, e.frm}) begin
                    errors++;
                    $display("FAIL %s: AN=%b SEG=%h frame=%b, required AN=%b SEG=%h frame=%b",
                             e.name, an, seg, frame, e.an, e.seg, e.frm);
                end
            end
        end
    end

    initial begin : stimulus
        base = 0;
        push_disp(2, 4'b1111, 8'hFF, 1'b0, "rst_hold_a");
        push_disp(3, 4'b1111, 8'hFF, 1'b0, "rst_hold_b");
        wait_until(4);
        rst_n = 1'b1;
        base  = cyc;

        // Free scan of value 0
        push_disp(1,  4'b1110, 8'hC0, 1'b0, "scan_first_edge");
        push_disp(4,  4'b1110, 8'hC0, 1'b0, "scan_d0_hold");
        push_disp(5,  4'b1101, 8'hC0, 1'b0, "scan_d1");
        push_disp(8,  4'b1101, 8'hC0, 1'b0, "scan_d1_hold");
        push_disp(9,  4'b1011, 8'hC0, 1'b0, "scan_d2");
        push_disp(13, 4'b0111, 8'hC0, 1'b0, "scan_d3");
        push_disp(16, 4'b0111, 8'hC0, 1'b0, "wrap_no_frame");
        push_disp(17, 4'b1110, 8'hC0, 1'b0, "scan_wrap_d0");
        // 1234 / points 0001, loaded mid digit 1
        push_disp(24, 4'b1101, 8'hC0, 1'b0, "pend_not_shown");
        push_disp(31, 4'b0111, 8'hC0, 1'b0, "pre_commit");
        push_disp(32, 4'b0111, 8'hC0, 1'b1, "commit_1234");
        push_disp(33, 4'b1110, 8'h19, 1'b0, "d0_4_point");
        push_disp(37, 4'b1101, 8'hB0, 1'b0, "d1_3");
        push_disp(41, 4'b1011, 8'hA4, 1'b0, "d2_2");
        push_disp(45, 4'b0111, 8'hF9, 1'b0, "d3_1");
        push_disp(48, 4'b0111, 8'hF9, 1'b0, "no_second_frame");
        push_cnt (49, 1, "frames_after_1234");
        // AAAA then BEEF within one frame
        push_disp(52, 4'b1110, 8'h19, 1'b0, "old_d0_kept");
        push_disp(56, 4'b1101, 8'hB0, 1'b0, "old_d1_kept");
        push_disp(63, 4'b0111, 8'hF9, 1'b0, "old_d3_kept");
        push_disp(64, 4'b0111, 8'hF9, 1'b1, "commit_beef");
        push_disp(65, 4'b1110, 8'h8E, 1'b0, "beef_d0_F");
        push_disp(69, 4'b1101, 8'h86, 1'b0, "beef_d1_E");
        push_disp(73, 4'b1011, 8'h86, 1'b0, "beef_d2_E");
        push_disp(77, 4'b0111, 8'h83, 1'b0, "beef_d3_b");
        push_disp(80, 4'b0111, 8'h83, 1'b0, "beef_single_frame");
        push_cnt (81, 2, "frames_after_beef");
        // FFFF pending, 5555 loaded on the commit edge
        push_disp(96,  4'b0111, 8'h83, 1'b1, "commit_ffff");
        push_disp(97,  4'b1110, 8'h8E, 1'b0, "ffff_d0");
        push_disp(101, 4'b1101, 8'h8E, 1'b0, "ffff_d1");
        push_disp(105, 4'b1011, 8'h8E, 1'b0, "ffff_d2");
        push_disp(109, 4'b0111, 8'h8E, 1'b0, "ffff_d3");
        push_disp(112, 4'b0111, 8'h8E, 1'b1, "commit_5555");
        push_disp(113, 4'b1110, 8'h92, 1'b0, "5555_d0");
        push_disp(117, 4'b1101, 8'h92, 1'b0, "5555_d1");
        push_cnt (118, 4, "frames_after_5555");
        // Blanking mid-scan
        push_disp(118, 4'b1101, 8'h92, 1'b0, "pre_blank");
        push_disp(119, 4'b1111, 8'hFF, 1'b0, "blank_start");
        push_disp(123, 4'b1111, 8'hFF, 1'b0, "blank_mid");
        push_disp(126, 4'b1111, 8'hFF, 1'b0, "blank_end");
        push_disp(127, 4'b0111, 8'h92, 1'b0, "unblank_phase_d3");
        push_disp(128, 4'b0111, 8'h92, 1'b0, "unblank_no_frame");
        push_disp(129, 4'b1110, 8'h92, 1'b0, "unblank_wrap_d0");
        // 1234 again, then reset mid-frame with 9999 pending
        push_disp(144, 4'b0111, 8'h92, 1'b1, "commit_1234_again");
        push_disp(145, 4'b1110, 8'h19, 1'b0, "1234_again_d0");
        push_cnt (146, 5, "frames_before_reset");
        push_disp(151, 4'b1101, 8'hB0, 1'b0, "pre_reset_d1");
        push_disp(152, 4'b1111, 8'hFF, 1'b0, "async_reset_now");
        push_disp(153, 4'b1111, 8'hFF, 1'b0, "async_reset_hold");

        load_at(22, 16'h1234, 4'b0001);
        load_at(50, 16'hAAAA, 4'b0000);
        load_at(55, 16'hBEEF, 4'b0000);
        load_at(82, 16'hFFFF, 4'b0000);
        load_at(96, 16'h5555, 4'b0000);
        wait_until(base + 118);
        le = 1'b1;
        wait_until(base + 126);
        le = 1'b0;
        load_at(131, 16'h1234, 4'b0001);
        load_at(150, 16'h9999, 4'b0000);
        wait_until(base + 152);
        rst_n = 1'b0;
        wait_until(base + 154);
        rst_n = 1'b1;
        base  = cyc;

        push_disp(1,  4'b1110, 8'hC0, 1'b0, "post_rst_d0");
        push_disp(5,  4'b1101, 8'hC0, 1'b0, "post_rst_d1");
        push_disp(16, 4'b0111, 8'hC0, 1'b0, "post_rst_no_commit");
        push_disp(17, 4'b1110, 8'hC0, 1'b0, "post_rst_pend_cleared");
        push_cnt (18, 5, "frames_after_reset");

        wait_until(base + 20);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            errors++;
            $display("FAIL %s: never sampled, required at cycle %0d", e.name, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
